// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types, geometry constants and column-to-half-column mapping for the LED matrix scanner
package matrix_pkg;
  localparam int MATRIX_COLS = 5;
  localparam int MATRIX_ROWS = 7;
  localparam int HALF_COLS = 3;
  localparam int GLYPH_W = 21;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_e;
  typedef logic [2:0] col_idx_t;
  localparam col_idx_t COL_LAST = 3'd4;
  // Mirrored glyphs: columns 0/4 share slice 2, 1/3 share slice 1, centre uses slice 0
  function automatic logic [1:0] half_col(input col_idx_t c);
    return (c == 3'd0 || c == 3'd4) ? 2'd2 : (c == 3'd2) ? 2'd0 : 2'd1;
  endfunction
endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: per-slot cycle counter with terminal-count and next-cycle blank-window flags
module scan_slot_timer #(
  parameter int SLOT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  output logic done,
  output logic blank_next
);
  localparam int W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  logic [W-1:0] count, count_next;
  // blank_next describes the count the next edge will load, so callers can register outputs
  always_comb begin
    done = count == W'(SLOT_CYCLES - 1);
    count_next = (!run || done) ? '0 : count + 1'b1;
    blank_next = int'(count_next) < BLANK_CYCLES;
  end
  always_ff @(posedge clock) begin
    if (clear) count <= '0;
    else count <= count_next;
  end
endmodule

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: frame-synchronised, blanked column scan of a 5x7 LED matrix with a per-frame glyph shadow
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int SLOT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic [GLYPH_W-1:0] glyph_data,
  output logic [MATRIX_COLS-1:0] col,
  output logic [MATRIX_ROWS-1:0] row,
  output logic frame_start,
  output logic scanning
);
  localparam logic [MATRIX_COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? '1 : '0;
  scan_state_e state, state_n;
  col_idx_t idx, idx_n;
  logic [GLYPH_W-1:0] shadow, shadow_n;
  logic run, done, blank_next, frame_n;
  logic [MATRIX_COLS-1:0] col_n;
  logic [MATRIX_ROWS-1:0] row_n;
  assign run = state != IDLE && enable;
  scan_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clock(clock),
    .clear(clear),
    .run(run),
    .done(done),
    .blank_next(blank_next)
  );
  always_comb begin
    state_n = !enable ? IDLE : blank_next ? BLANK : DRIVE;
    frame_n = enable && (state == IDLE || (done && idx == COL_LAST));
    idx_n = (!run || frame_n) ? '0 : done ? idx + 1'b1 : idx;
    shadow_n = frame_n ? glyph_data : shadow;
  end
  // Outputs are computed from next-state values so the registers match the state they enter
  always_comb begin
    col_n = (state_n == DRIVE) ? COL_OFF ^ (MATRIX_COLS'(1) << idx_n) : COL_OFF;
    row_n = (state_n == DRIVE) ? shadow_n[MATRIX_ROWS*int'(half_col(idx_n)) +: MATRIX_ROWS] : '0;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      idx <= '0;
      shadow <= '0;
      col <= COL_OFF;
      row <= '0;
      frame_start <= 1'b0;
      scanning <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      shadow <= shadow_n;
      col <= col_n;
      row <= row_n;
      frame_start <= frame_n;
      scanning <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: directed checks of scan order, blanking, glyph latching, enable and clear behaviour
module tb_matrix_scan_controller;
  logic clock = 1'b0;
  logic clear, enable;
  logic [20:0] glyph_data;
  logic [4:0] col;
  logic [6:0] row;
  logic frame_start, scanning;
  int passed = 0;
  int total = 0;
  logic [20:0] shown;
  logic [20:0] glyphs [10] = '{21'h000001, 21'h1FC000, 21'h003F80, 21'h00007F, 21'h155555,
                               21'h0AAAAA, 21'h100040, 21'h041041, 21'h1FFFFF, 21'h000000};

  matrix_scan_controller #(.SLOT_CYCLES(8), .BLANK_CYCLES(2), .COL_ACTIVE_LOW(1'b1)) dut (
    .clock(clock),
    .clear(clear),
    .enable(enable),
    .glyph_data(glyph_data),
    .col(col),
    .row(row),
    .frame_start(frame_start),
    .scanning(scanning)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (scanning)
      assert (col == 5'h1F || $onehot(~col)) else $error("FAIL col_onehot col=%b", col);
    else
      assert (col == 5'h1F && row == 7'h00) else $error("FAIL idle_dark col=%b row=%h", col, row);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] exp_row(input logic [20:0] g, input int c);
    case (c)
      0, 4: return g[20:14];
      1, 3: return g[13:7];
      default: return g[6:0];
    endcase
  endfunction

  task automatic check_dark(input string tag);
    check({tag, "_col"}, 32'(col), 32'h1F);
    check({tag, "_row"}, 32'(row), 32'h0);
    check({tag, "_fs"}, 32'(frame_start), 32'h0);
    check({tag, "_scan"}, 32'(scanning), 32'h0);
  endtask

  // Starts sampled at cycle 0 of a frame; checks n cycles, optionally swapping glyph_data at cycle chg
  task automatic run_frame(input logic [20:0] g, input int n, input int chg, input logic [20:0] g_new);
    for (int k = 0; k < n; k++) begin
      int c, t;
      c = k / 8;
      t = k % 8;
      check($sformatf("k%0d_col", k), 32'(col), t < 2 ? 32'h1F : 32'(5'h1F ^ (5'b1 << c)));
      check($sformatf("k%0d_row", k), 32'(row), t < 2 ? 32'h0 : 32'(exp_row(g, c)));
      check($sformatf("k%0d_fs", k), 32'(frame_start), 32'(k == 0));
      check($sformatf("k%0d_scan", k), 32'(scanning), 32'h1);
      if (k == chg) glyph_data = g_new;
      tick();
    end
  endtask

  initial begin
    clear = 1'b1;
    enable = 1'b1;
    glyph_data = 21'h1FC07F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_dark($sformatf("reset%0d", i));
    end
    clear = 1'b0;
    tick();
    run_frame(21'h1FC07F, 40, -1, '0);
    run_frame(21'h1FC07F, 40, 5, 21'h000000);
    run_frame(21'h000000, 40, 12, 21'h000041);
    run_frame(21'h000041, 40, -1, '0);
    run_frame(21'h000041, 26, -1, '0);
    check("col3_drive", 32'(col), 32'h17);
    enable = 1'b0;
    tick();
    check_dark("dis0");
    tick();
    check_dark("dis1");
    glyph_data = 21'h1FC07F;
    enable = 1'b1;
    tick();
    run_frame(21'h1FC07F, 40, -1, '0);
    run_frame(21'h1FC07F, 10, -1, '0);
    check("col1_drive", 32'(col), 32'h1D);
    clear = 1'b1;
    tick();
    check_dark("clr");
    clear = 1'b0;
    tick();
    run_frame(21'h1FC07F, 40, -1, '0);
    shown = 21'h1FC07F;
    for (int i = 0; i < 10; i++) begin
      run_frame(shown, 40, 20, glyphs[i]);
      shown = glyphs[i];
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
